// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection: pedestrian FSM state encoding,
// the one-hot lamp codes driven by the traffic light controller, and the
// helpers both blocks use to interpret those lamps.
package traffic_pkg;

  // Pedestrian signal FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WALK  = 2'b01,
    ST_CLEAR = 2'b10
  } ped_state_e;

  // Traffic light controller states, listed here so both controllers agree
  // on which lamp pattern belongs to which phase.
  typedef enum logic [1:0] {
    TL_GREEN  = 2'b00,
    TL_YELLOW = 2'b01,
    TL_RED    = 2'b10
  } light_state_e;

  // Lamp codes, ordered {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Phase durations are carried in a 4-bit countdown.
  localparam int unsigned TICKS_MAX = 15;

  // True when exactly one lamp is lit with a legal code.
  function automatic logic lamps_one_hot(input logic [2:0] lamps);
    return (lamps == LAMP_RED) || (lamps == LAMP_YELLOW) || (lamps == LAMP_GREEN);
  endfunction

  // Lamp pattern the traffic light controller drives in a given phase.
  function automatic logic [2:0] lamps_for(input light_state_e state);
    logic [2:0] lamps;
    lamps = LAMP_RED;
    case (state)
      TL_GREEN:  lamps = LAMP_GREEN;
      TL_YELLOW: lamps = LAMP_YELLOW;
      default:   lamps = LAMP_RED;
    endcase
    return lamps;
  endfunction

  // Converts a tick-count parameter to the countdown width, saturating at
  // the largest representable count.
  function automatic logic [3:0] ticks_to_count(input int unsigned ticks);
    logic [3:0] count;
    if (ticks > TICKS_MAX) count = 4'(TICKS_MAX);
    else                   count = 4'(ticks);
    return count;
  endfunction

endpackage

// File: rtl/pedestrian_signal_if.sv
// Signal bundle between the pedestrian signal and its environment: the
// upstream lamp/enable inputs, the push-button, and the pedestrian lamps and
// status outputs. The master drives the lamps and button; the slave is the
// pedestrian signal itself.
interface pedestrian_signal_if;

  logic       enable;
  logic       red;
  logic       yellow;
  logic       green;
  logic       button;

  logic       walk;
  logic       dont_walk;
  logic       pending;
  logic [3:0] countdown;
  logic       fault;

  modport master (
    output enable, red, yellow, green, button,
    input  walk, dont_walk, pending, countdown, fault
  );

  modport slave (
    input  enable, red, yellow, green, button,
    output walk, dont_walk, pending, countdown, fault
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector. o_rise is high for exactly one cycle, two cycles after the input
// is first captured.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge
    // value of its neighbour, which is what turns this into a shift chain.
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_sync_q;

endmodule

// File: rtl/pedestrian_signal.sv
// Pedestrian crossing signal slaved to a traffic light controller. A button
// press is latched as a request and served when the upstream light next
// turns red: walk for WALK_TICKS enable ticks, then a flashing don't-walk
// clearance for CLEAR_TICKS ticks. Illegal lamp patterns, or red dropping
// while pedestrians have the crossing, raise a sticky fault that forces the
// crossing to don't-walk until reset.
module pedestrian_signal
  import traffic_pkg::*;
#(
  parameter int unsigned WALK_TICKS  = 3,
  parameter int unsigned CLEAR_TICKS = 2
) (
  input logic             clk,
  input logic             reset,
  pedestrian_signal_if.slave bus
);

  localparam logic [3:0] WALK_COUNT  = ticks_to_count(WALK_TICKS);
  localparam logic [3:0] CLEAR_COUNT = ticks_to_count(CLEAR_TICKS);

  ped_state_e r_state;
  logic       r_red_q;
  logic       r_walk;
  logic       r_dont_walk;
  logic       r_pending;
  logic [3:0] r_countdown;
  logic       r_fault;

  logic       w_btn_rise;
  logic       w_red_rise;
  logic [2:0] w_lamps;
  logic       w_lamp_fault;
  logic       w_red_drop;
  logic       w_start;
  logic       w_last_tick;

  sync_edge u_btn_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.button),
    .o_rise  (w_btn_rise)
  );

  // Delayed red for edge detection; resets high so a red lamp that is
  // already lit out of reset is not mistaken for a new red phase.
  always_ff @(posedge clk) begin
    if (reset) r_red_q <= 1'b1;
    else       r_red_q <= bus.red;
  end

  assign w_red_rise   = bus.red & ~r_red_q;
  assign w_lamps      = {bus.red, bus.yellow, bus.green};
  assign w_lamp_fault = ~lamps_one_hot(w_lamps);
  assign w_red_drop   = (r_state != ST_IDLE) & ~bus.red;
  assign w_start      = w_red_rise & (r_pending | w_btn_rise) & ~r_fault;
  assign w_last_tick  = (r_countdown == 4'd1);

  // Crossing FSM with registered lamp, request, countdown and fault outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_pending   <= 1'b0;
      r_countdown <= 4'd0;
      r_fault     <= 1'b0;
    end else if (w_lamp_fault || w_red_drop) begin
      // Unsafe upstream state: abandon any crossing, keep requests queued.
      r_state     <= ST_IDLE;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_countdown <= 4'd0;
      r_fault     <= 1'b1;
      r_pending   <= r_pending | w_btn_rise;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_walk      <= 1'b0;
          r_dont_walk <= 1'b1;
          r_countdown <= 4'd0;
          if (w_start) begin
            // A press arriving on the same cycle is served by this crossing.
            r_state     <= ST_WALK;
            r_walk      <= 1'b1;
            r_dont_walk <= 1'b0;
            r_countdown <= WALK_COUNT;
            r_pending   <= 1'b0;
          end else begin
            r_pending   <= r_pending | w_btn_rise;
          end
        end

        ST_WALK: begin
          r_pending <= r_pending | w_btn_rise;
          if (bus.enable) begin
            if (w_last_tick) begin
              r_state     <= ST_CLEAR;
              r_walk      <= 1'b0;
              r_dont_walk <= 1'b1;
              r_countdown <= CLEAR_COUNT;
            end else begin
              r_countdown <= r_countdown - 4'd1;
            end
          end
        end

        ST_CLEAR: begin
          r_pending <= r_pending | w_btn_rise;
          if (bus.enable) begin
            if (w_last_tick) begin
              r_state     <= ST_IDLE;
              r_dont_walk <= 1'b1;
              r_countdown <= 4'd0;
            end else begin
              // Flash: don't-walk toggles once per tick of clearance.
              r_dont_walk <= ~r_dont_walk;
              r_countdown <= r_countdown - 4'd1;
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_walk      <= 1'b0;
          r_dont_walk <= 1'b1;
          r_countdown <= 4'd0;
        end
      endcase
    end
  end

  assign bus.walk      = r_walk;
  assign bus.dont_walk = r_dont_walk;
  assign bus.pending   = r_pending;
  assign bus.countdown = r_countdown;
  assign bus.fault     = r_fault;

endmodule

// File: tb/tb_pedestrian_signal.sv
// Directed bench for pedestrian_signal with default tick parameters.
// Inputs change 1 time unit after a rising edge; outputs are checked there
// too, so each check sees the result of the edge just taken.
module tb_pedestrian_signal;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  bit   mon_en       = 1'b0;

  pedestrian_signal_if bus_if ();

  pedestrian_signal #(
    .WALK_TICKS  (3),
    .CLEAR_TICKS (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lamps(input logic [2:0] lamps);
    {bus_if.red, bus_if.yellow, bus_if.green} = lamps;
  endtask

  task automatic expect_outs(input string tag, input logic walk, input logic dont_walk,
                             input logic pending, input logic [3:0] countdown,
                             input logic fault);
    check({tag, ".walk"},      32'(bus_if.walk),      32'(walk));
    check({tag, ".dont_walk"}, 32'(bus_if.dont_walk), 32'(dont_walk));
    check({tag, ".pending"},   32'(bus_if.pending),   32'(pending));
    check({tag, ".countdown"}, 32'(bus_if.countdown), 32'(countdown));
    check({tag, ".fault"},     32'(bus_if.fault),     32'(fault));
  endtask

  // Walk and don't-walk must never be lit together.
  always @(negedge clk) begin
    if (mon_en) check("walk_and_dont_walk", 32'(bus_if.walk & bus_if.dont_walk), 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus_if.enable = 1'b0;
    bus_if.button = 1'b0;
    set_lamps(LAMP_RED);
    step(2);
    expect_outs("reset", 0, 1, 0, 4'd0, 0);
    mon_en = 1'b1;

    // Red held through reset, then a full light cycle with no request.
    reset = 1'b0;
    step(2);
    expect_outs("reset_red_hold", 0, 1, 0, 4'd0, 0);
    set_lamps(LAMP_GREEN);  step(1);
    set_lamps(LAMP_YELLOW); step(1);
    set_lamps(LAMP_RED);    step(1);
    expect_outs("no_button_cycle", 0, 1, 0, 4'd0, 0);

    // Press during green, serve at red with enable every cycle.
    set_lamps(LAMP_GREEN); step(1);
    bus_if.button = 1'b1;
    step(2);
    check("sync_latency_2", 32'(bus_if.pending), 32'd0);
    step(1);
    check("sync_latency_3", 32'(bus_if.pending), 32'd1);
    bus_if.button = 1'b0;
    set_lamps(LAMP_YELLOW); step(1);
    set_lamps(LAMP_RED);
    bus_if.enable = 1'b1;
    step(1); expect_outs("walk_cd3",         1, 0, 0, 4'd3, 0);
    step(1); expect_outs("walk_cd2",         1, 0, 0, 4'd2, 0);
    step(1); expect_outs("walk_cd1",         1, 0, 0, 4'd1, 0);
    step(1); expect_outs("clear_cd2",        0, 1, 0, 4'd2, 0);
    step(1); expect_outs("clear_cd1",        0, 0, 0, 4'd1, 0);
    step(1); expect_outs("idle_after_clear", 0, 1, 0, 4'd0, 0);

    // Press during WALK is queued and served at the following red.
    bus_if.enable = 1'b0;
    set_lamps(LAMP_GREEN); step(1);
    bus_if.button = 1'b1;  step(3);
    bus_if.button = 1'b0;
    set_lamps(LAMP_YELLOW); step(1);
    set_lamps(LAMP_RED);    step(1);
    expect_outs("walk2_entry", 1, 0, 0, 4'd3, 0);
    bus_if.button = 1'b1;
    step(2);
    check("walk_sync_latency_2", 32'(bus_if.pending), 32'd0);
    step(1);
    expect_outs("walk_hold_pending", 1, 0, 1, 4'd3, 0);
    bus_if.button = 1'b0;
    bus_if.enable = 1'b1;
    step(5);
    expect_outs("idle_pending_kept", 0, 1, 1, 4'd0, 0);
    bus_if.enable = 1'b0;
    set_lamps(LAMP_GREEN);  step(1);
    set_lamps(LAMP_YELLOW); step(1);
    set_lamps(LAMP_RED);    step(1);
    expect_outs("pending_served", 1, 0, 0, 4'd3, 0);
    bus_if.enable = 1'b1;
    step(5);
    expect_outs("idle_again", 0, 1, 0, 4'd0, 0);
    bus_if.enable = 1'b0;

    // Synchronized press lands on the same edge as red rising: absorbed.
    set_lamps(LAMP_GREEN); step(1);
    bus_if.button = 1'b1;  step(2);
    set_lamps(LAMP_RED);   step(1);
    expect_outs("absorb_entry", 1, 0, 0, 4'd3, 0);
    bus_if.button = 1'b0;
    step(1);
    expect_outs("absorb_after", 1, 0, 0, 4'd3, 0);

    // Red dropped to green mid-WALK: fault, and later requests are not served.
    bus_if.enable = 1'b1; step(1);
    expect_outs("walk_cd2_pre_drop", 1, 0, 0, 4'd2, 0);
    bus_if.enable = 1'b0;
    set_lamps(LAMP_GREEN); step(1);
    expect_outs("red_drop", 0, 1, 0, 4'd0, 1);
    bus_if.button = 1'b1; step(3);
    bus_if.button = 1'b0;
    set_lamps(LAMP_YELLOW); step(1);
    set_lamps(LAMP_RED);    step(1);
    expect_outs("fault_blocks", 0, 1, 1, 4'd0, 1);

    reset = 1'b1; step(1);
    reset = 1'b0;
    expect_outs("reset_clears_fault", 0, 1, 0, 4'd0, 0);

    // Red held from reset never counts as a red rise, even with a request.
    bus_if.button = 1'b1; step(3);
    bus_if.button = 1'b0; step(1);
    expect_outs("reset_red_no_rise", 0, 1, 1, 4'd0, 0);
    set_lamps(LAMP_GREEN);  step(1);
    set_lamps(LAMP_YELLOW); step(1);
    set_lamps(LAMP_RED);    step(1);
    expect_outs("walk3_entry", 1, 0, 0, 4'd3, 0);

    // Reset during CLEAR with enable low.
    bus_if.enable = 1'b1;
    bus_if.button = 1'b1;
    step(3);
    expect_outs("clear_pending", 0, 1, 1, 4'd2, 0);
    bus_if.button = 1'b0;
    bus_if.enable = 1'b0;
    step(1);
    expect_outs("clear_hold", 0, 1, 1, 4'd2, 0);
    reset = 1'b1; step(1);
    expect_outs("reset_mid_clear", 0, 1, 0, 4'd0, 0);
    reset = 1'b0;
    bus_if.button = 1'b1; step(3);
    bus_if.button = 1'b0; step(1);
    expect_outs("post_reset_no_walk", 0, 1, 1, 4'd0, 0);

    // Red and green together mid-WALK: fault is sticky until reset.
    set_lamps(LAMP_GREEN);  step(1);
    set_lamps(LAMP_YELLOW); step(1);
    set_lamps(LAMP_RED);    step(1);
    expect_outs("walk4_entry", 1, 0, 0, 4'd3, 0);
    set_lamps(LAMP_RED | LAMP_GREEN); step(1);
    expect_outs("not_one_hot", 0, 1, 0, 4'd0, 1);
    set_lamps(LAMP_RED);   step(1);
    set_lamps(LAMP_GREEN); step(1);
    bus_if.button = 1'b1;  step(3);
    bus_if.button = 1'b0;
    set_lamps(LAMP_YELLOW); step(1);
    set_lamps(LAMP_RED);    step(1);
    expect_outs("fault_sticky", 0, 1, 1, 4'd0, 1);
    reset = 1'b1; step(1);
    reset = 1'b0;
    expect_outs("final_reset", 0, 1, 0, 4'd0, 0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
